// File: rtl/uart_io_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_io_ctrl
//  Description : Responder side of the exec-stage UART handshake.
//                TX: one-entry hold register feeding an 8N1 shifter on txd.
//                RX: 2-FF synchroniser, 8N1 deserialiser, RX FIFO; bytes are
//                returned to exec on read requests (or bypass the FIFO when a
//                read is already waiting).
//  Ports       : clk, rstn (sync, active low)
//                uart_wenable/uart_wd -> uart_wdone   (write handshake)
//                uart_renable         -> uart_rd/uart_rdone (read handshake)
//                rxd / txd            serial pins, idle high, LSB first
//                rx_overflow          sticky, byte dropped on full FIFO
//                rx_frame_err         sticky, stop bit sampled low
//  Revision    : 1.0  initial release
// ============================================================================
module uart_io_ctrl #(
    parameter int CLK_PER_BIT = 868,
    parameter int RX_DEPTH    = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_wenable,
    input  logic [31:0] uart_wd,
    output logic        uart_wdone,
    input  logic        uart_renable,
    output logic [31:0] uart_rd,
    output logic        uart_rdone,
    input  logic        rxd,
    output logic        txd,
    output logic        rx_overflow,
    output logic        rx_frame_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(CLK_PER_BIT);
    localparam int c_AW    = $clog2(RX_DEPTH);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_AW:0]      c_PTR_ONE  = {{c_AW{1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // Upper write-data bits carry nothing for a byte-wide UART.
    logic w_unused_wd;
    assign w_unused_wd = ^uart_wd[31:8];

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    logic [1:0]         r_tx_state;
    logic [c_CNT_W-1:0] r_tx_cnt;
    logic [2:0]         r_tx_bit;
    logic [7:0]         r_tx_shift;
    logic               r_txd;
    logic               r_hold_valid;
    logic [7:0]         r_hold_byte;
    logic               r_wdone;

    logic               w_tx_bit_end;
    logic               w_tx_free;
    logic               w_wr_accept;
    logic               w_tx_load;
    logic [7:0]         w_tx_load_byte;

    assign w_tx_bit_end = (r_tx_cnt == c_CNT_LAST);

    // The shifter can take a new byte when idle, or on the last cycle of STOP
    // so that the next start bit follows without an idle gap.
    assign w_tx_free = (r_tx_state == c_ST_IDLE) ||
                       ((r_tx_state == c_ST_STOP) && w_tx_bit_end);

    // A full hold register means a write is still unacknowledged; any further
    // request is a protocol violation and is dropped.
    assign w_wr_accept    = uart_wenable && !r_hold_valid;
    assign w_tx_load      = w_tx_free && (r_hold_valid || w_wr_accept);
    assign w_tx_load_byte = r_hold_valid ? r_hold_byte : uart_wd[7:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tx_state   <= c_ST_IDLE;
            r_tx_cnt     <= c_CNT_ZERO;
            r_tx_bit     <= 3'd0;
            r_tx_shift   <= 8'h00;
            r_txd        <= 1'b1;
            r_hold_valid <= 1'b0;
            r_hold_byte  <= 8'h00;
            r_wdone      <= 1'b0;
        end else begin
            r_wdone <= w_tx_load;

            if (w_tx_load) begin
                r_tx_state <= c_ST_START;
                r_tx_cnt   <= c_CNT_ZERO;
                r_tx_shift <= w_tx_load_byte;
                r_txd      <= 1'b0;
            end else begin
                case (r_tx_state)
                    c_ST_START: begin
                        if (w_tx_bit_end) begin
                            r_tx_state <= c_ST_DATA;
                            r_tx_cnt   <= c_CNT_ZERO;
                            r_tx_bit   <= 3'd0;
                            r_txd      <= r_tx_shift[0];
                        end else begin
                            r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_DATA: begin
                        if (w_tx_bit_end) begin
                            r_tx_cnt <= c_CNT_ZERO;
                            if (r_tx_bit == 3'd7) begin
                                r_tx_state <= c_ST_STOP;
                                r_txd      <= 1'b1;
                            end else begin
                                r_tx_bit   <= r_tx_bit + 3'd1;
                                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                                r_txd      <= r_tx_shift[1];
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                        end
                    end
                    c_ST_STOP: begin
                        if (w_tx_bit_end) begin
                            r_tx_state <= c_ST_IDLE;
                            r_tx_cnt   <= c_CNT_ZERO;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        r_tx_cnt <= c_CNT_ZERO;
                    end
                endcase
            end

            // Hold register: drained by a load, filled by a write that
            // arrives while the shifter is busy.
            if (w_tx_load && r_hold_valid) begin
                r_hold_valid <= 1'b0;
            end else if (w_wr_accept && !w_tx_free) begin
                r_hold_valid <= 1'b1;
                r_hold_byte  <= uart_wd[7:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // RX synchroniser and deserialiser
    // ------------------------------------------------------------------------
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    logic [1:0]         r_rx_state;
    logic [c_CNT_W-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;

    logic               w_rx_stop_sample;
    logic               w_rx_good;
    logic               w_rx_bad;

    assign w_rx_stop_sample = (r_rx_state == c_ST_STOP) && (r_rx_cnt == c_CNT_LAST);
    assign w_rx_good        = w_rx_stop_sample &&  r_rx_sync;
    assign w_rx_bad         = w_rx_stop_sample && !r_rx_sync;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= c_ST_IDLE;
            r_rx_cnt   <= c_CNT_ZERO;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_meta <= rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;

            case (r_rx_state)
                c_ST_IDLE: begin
                    r_rx_cnt <= c_CNT_ZERO;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    // Mid start bit: a line already back high was a glitch.
                    if (r_rx_cnt == c_CNT_HALF) begin
                        r_rx_cnt <= c_CNT_ZERO;
                        r_rx_bit <= 3'd0;
                        r_rx_state <= r_rx_sync ? c_ST_IDLE : c_ST_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DATA: begin
                    if (r_rx_cnt == c_CNT_LAST) begin
                        r_rx_cnt   <= c_CNT_ZERO;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= c_ST_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    // STOP: leave at mid-bit so a following start edge is seen.
                    if (r_rx_cnt == c_CNT_LAST) begin
                        r_rx_cnt   <= c_CNT_ZERO;
                        r_rx_state <= c_ST_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // RX FIFO and read handshake
    // ------------------------------------------------------------------------
    logic [7:0]  r_fifo_mem [RX_DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic        r_rd_pending;
    logic        r_rd_defer;
    logic [7:0]  r_defer_byte;
    logic [7:0]  r_rd_byte;
    logic        r_rdone;
    logic        r_overflow;
    logic        r_frame_err;

    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_rd_req;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic        w_drop;
    logic        w_rd_fire;
    logic [7:0]  w_rd_fire_byte;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                          (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // New requests are ignored while one is pending or a deferred response
    // is still waiting for its slot.
    assign w_rd_req = r_rd_pending || (uart_renable && !r_rd_defer);
    assign w_pop    = w_rd_req && !w_fifo_empty;
    assign w_bypass = w_rd_req &&  w_fifo_empty && w_rx_good;
    assign w_push   = w_rx_good && !w_bypass && (!w_fifo_full || w_pop);
    assign w_drop   = w_rx_good && !w_bypass &&  w_fifo_full && !w_pop;

    assign w_rd_fire      = w_pop || w_bypass;
    assign w_rd_fire_byte = w_pop ? r_fifo_mem[r_rd_ptr[c_AW-1:0]] : r_rx_shift;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[c_AW-1:0]] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rd_pending <= 1'b0;
            r_rd_defer   <= 1'b0;
            r_defer_byte <= 8'h00;
            r_rd_byte    <= 8'h00;
            r_rdone      <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            r_rd_pending <= w_rd_req && !w_rd_fire;

            // wdone wins a collision; the read response slips one cycle and
            // uart_rd only changes when its rdone is finally issued.
            if (w_rd_fire && w_tx_load) begin
                r_rd_defer   <= 1'b1;
                r_defer_byte <= w_rd_fire_byte;
                r_rdone      <= 1'b0;
            end else if (w_rd_fire) begin
                r_rd_defer <= 1'b0;
                r_rd_byte  <= w_rd_fire_byte;
                r_rdone    <= 1'b1;
            end else if (r_rd_defer) begin
                r_rd_defer <= 1'b0;
                r_rd_byte  <= r_defer_byte;
                r_rdone    <= 1'b1;
            end else begin
                r_rdone <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_rx_bad) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign txd          = r_txd;
    assign uart_wdone   = r_wdone;
    assign uart_rdone   = r_rdone;
    assign uart_rd      = {24'h000000, r_rd_byte};
    assign rx_overflow  = r_overflow;
    assign rx_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_io_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_io_ctrl
//  Description : Directed self-checking bench for uart_io_ctrl with
//                CLK_PER_BIT=4, RX_DEPTH=4. One task per scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_io_ctrl;

    localparam int c_CPB = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        uart_wenable;
    logic [31:0] uart_wd;
    logic        uart_wdone;
    logic        uart_renable;
    logic [31:0] uart_rd;
    logic        uart_rdone;
    logic        rxd;
    logic        txd;
    logic        rx_overflow;
    logic        rx_frame_err;

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc            = 0;
    int wdone_cnt      = 0;
    int rdone_cnt      = 0;
    int both_cnt       = 0;
    int last_wdone_cyc = -1;
    int last_rdone_cyc = -1;
    logic [31:0] last_rd = 32'h0;
    int rx_lat = 41;

    uart_io_ctrl #(
        .CLK_PER_BIT (c_CPB),
        .RX_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .uart_wenable (uart_wenable),
        .uart_wd      (uart_wd),
        .uart_wdone   (uart_wdone),
        .uart_renable (uart_renable),
        .uart_rd      (uart_rd),
        .uart_rdone   (uart_rdone),
        .rxd          (rxd),
        .txd          (txd),
        .rx_overflow  (rx_overflow),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (uart_wdone) begin
            wdone_cnt      <= wdone_cnt + 1;
            last_wdone_cyc <= cyc;
        end
        if (uart_rdone) begin
            rdone_cnt      <= rdone_cnt + 1;
            last_rdone_cyc <= cyc;
            last_rd        <= uart_rd;
        end
        if (uart_wdone && uart_rdone) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0)      return 1'b0;
        else if (idx >= 9) return 1'b1;
        else               return b[idx-1];
    endfunction

    // Called at the start of the cycle in which the start bit begins.
    task automatic drive_rx(input logic [7:0] b, input logic stop);
        for (int j = 0; j < 10; j++) begin
            rxd = (j == 9) ? stop : frame_bit(b, j);
            repeat (c_CPB) tick();
        end
        rxd = 1'b1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        uart_wenable = 1'b0;
        uart_renable = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        uart_wenable = 1'b0;
        uart_renable = 1'b0;
        uart_wd = 32'h0;
        rxd = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({txd, uart_wdone, uart_rdone, rx_overflow, rx_frame_err} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got txd,wdone,rdone,ovf,ferr=%b required 10000",
                     {txd, uart_wdone, uart_rdone, rx_overflow, rx_frame_err});
        end
        tests_run++;
        if (uart_rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rd: got %h required 00000000", uart_rd);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_tx_byte();
        int n0;
        int w0;
        logic e;
        w0 = wdone_cnt;
        tick();
        n0 = cyc;
        uart_wenable = 1'b1;
        uart_wd = 32'hFFFF_FFA5;
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_idle: got %b required 1", txd);
        end
        for (int i = 1; i <= 44; i++) begin
            tick();
            uart_wenable = 1'b0;
            uart_wd = 32'h0;
            e = (i <= 40) ? frame_bit(8'hA5, (i-1)/c_CPB) : 1'b1;
            tests_run++;
            if (txd !== e) begin
                tests_failed++;
                $display("FAIL tx_a5_bit: cycle N+%0d txd got %b required %b", i, txd, e);
            end
            if (i == 1) begin
                tests_run++;
                if (uart_wdone !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL tx_wdone: got %b required 1 at N+1", uart_wdone);
                end
            end
        end
        tests_run++;
        if (wdone_cnt - w0 !== 1 || last_wdone_cyc !== n0 + 1) begin
            tests_failed++;
            $display("FAIL tx_wdone_count: got %0d pulses last at N+%0d required 1 at N+1",
                     wdone_cnt - w0, last_wdone_cyc - n0);
        end
    endtask

    task automatic test_tx_back_to_back();
        int n0;
        int w0;
        logic e;
        w0 = wdone_cnt;
        tick();
        n0 = cyc;
        uart_wenable = 1'b1;
        uart_wd = 32'h0000_005A;
        for (int i = 1; i <= 84; i++) begin
            tick();
            uart_wenable = (i == 2);
            uart_wd = (i == 2) ? 32'h1234_56C3 : 32'h0;
            if (i <= 40)      e = frame_bit(8'h5A, (i-1)/c_CPB);
            else if (i <= 80) e = frame_bit(8'hC3, (i-41)/c_CPB);
            else              e = 1'b1;
            tests_run++;
            if (txd !== e) begin
                tests_failed++;
                $display("FAIL b2b_bit: cycle N+%0d txd got %b required %b", i, txd, e);
            end
        end
        tests_run++;
        if (wdone_cnt - w0 !== 2 || last_wdone_cyc !== n0 + 41) begin
            tests_failed++;
            $display("FAIL b2b_wdone: got %0d pulses last at N+%0d required 2 last at N+41",
                     wdone_cnt - w0, last_wdone_cyc - n0);
        end
    endtask

    task automatic test_rx_pending();
        int k;
        int r0;
        tick();
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        r0 = rdone_cnt;
        tick();
        k = cyc;
        drive_rx(8'h3C, 1'b1);
        repeat (6) tick();
        rx_lat = last_rdone_cyc - k;
        tests_run++;
        if (rdone_cnt - r0 !== 1 || last_rd !== 32'h0000_003C) begin
            tests_failed++;
            $display("FAIL rx_pending: got %0d rdone rd=%h required 1 rdone rd=0000003c",
                     rdone_cnt - r0, last_rd);
        end
        tests_run++;
        if (rx_lat < 38 || rx_lat > 44) begin
            tests_failed++;
            $display("FAIL rx_latency: rdone at start+%0d required start+38..44", rx_lat);
        end
        tests_run++;
        if (uart_rd !== 32'h0000_003C) begin
            tests_failed++;
            $display("FAIL rx_rd_hold: got %h required 0000003c", uart_rd);
        end
        // The bypassed byte must not also sit in the FIFO.
        r0 = rdone_cnt;
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        repeat (15) tick();
        tests_run++;
        if (rdone_cnt !== r0) begin
            tests_failed++;
            $display("FAIL rx_fifo_empty: got %0d rdone required 0", rdone_cnt - r0);
        end
        apply_reset();
    endtask

    task automatic test_rx_overflow();
        int r0;
        r0 = rdone_cnt;
        tick();
        for (int f = 1; f <= 5; f++) drive_rx(8'(f), 1'b1);
        repeat (6) tick();
        tests_run++;
        if (rx_overflow !== 1'b1 || rx_frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_flags: got ovf=%b ferr=%b required ovf=1 ferr=0",
                     rx_overflow, rx_frame_err);
        end
        tests_run++;
        if (rdone_cnt !== r0) begin
            tests_failed++;
            $display("FAIL ovf_no_read: got %0d rdone required 0", rdone_cnt - r0);
        end
        for (int f = 1; f <= 4; f++) begin
            uart_renable = 1'b1;
            tick();
            uart_renable = 1'b0;
            tests_run++;
            if (uart_rdone !== 1'b1 || uart_rd !== 32'(f)) begin
                tests_failed++;
                $display("FAIL ovf_read: rdone=%b rd=%h required rdone=1 rd=%h",
                         uart_rdone, uart_rd, 32'(f));
            end
            tick();
        end
        // Fifth byte was dropped: this read must find the FIFO empty.
        r0 = rdone_cnt;
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        repeat (12) tick();
        tests_run++;
        if (rdone_cnt !== r0) begin
            tests_failed++;
            $display("FAIL ovf_lost: got %0d rdone rd=%h required 0", rdone_cnt - r0, uart_rd);
        end
    endtask

    task automatic test_frame_err();
        int r0;
        r0 = rdone_cnt;
        drive_rx(8'hE7, 1'b0);
        repeat (8) tick();
        tests_run++;
        if (rx_frame_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL ferr_flag: got %b required 1", rx_frame_err);
        end
        tests_run++;
        if (rdone_cnt !== r0) begin
            tests_failed++;
            $display("FAIL ferr_stored: got %0d rdone required 0", rdone_cnt - r0);
        end
        drive_rx(8'h77, 1'b1);
        repeat (6) tick();
        tests_run++;
        if (rdone_cnt - r0 !== 1 || uart_rd !== 32'h0000_0077) begin
            tests_failed++;
            $display("FAIL ferr_next: got %0d rdone rd=%h required 1 rd=00000077",
                     rdone_cnt - r0, uart_rd);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        tick();
        uart_wenable = 1'b1;
        uart_wd = 32'h0;
        tick();
        uart_wenable = 1'b0;
        repeat (10) tick();
        rstn = 1'b0;
        tick();
        tests_run++;
        if (txd !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_txd: got %b required 1", txd);
        end
        tick();
        tick();
        tests_run++;
        if ({uart_wdone, uart_rdone, rx_overflow, rx_frame_err} !== 4'b0000 ||
            uart_rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: wdone,rdone,ovf,ferr=%b rd=%h required 0000 rd=0",
                     {uart_wdone, uart_rdone, rx_overflow, rx_frame_err}, uart_rd);
        end
        rstn = 1'b1;
        w0 = wdone_cnt;
        repeat (20) tick();
        tests_run++;
        if (txd !== 1'b1 || wdone_cnt !== w0) begin
            tests_failed++;
            $display("FAIL rst_mid_idle: txd=%b wdone=%0d required txd=1 wdone=0",
                     txd, wdone_cnt - w0);
        end
    endtask

    task automatic test_collision();
        int w0;
        int r0;
        int b0;
        int lc;
        int n_coll;
        lc = (rx_lat < 38) ? 38 : ((rx_lat > 44) ? 44 : rx_lat);
        tick();
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        w0 = wdone_cnt;
        r0 = rdone_cnt;
        b0 = both_cnt;
        n_coll = 0;
        fork
            begin
                repeat (5) tick();
                n_coll = cyc;
                uart_wenable = 1'b1;
                uart_wd = 32'h11;
                tick();
                uart_wenable = 1'b0;
                tick();
                uart_wenable = 1'b1;
                uart_wd = 32'h22;
                tick();
                uart_wenable = 1'b0;
            end
            begin
                repeat (5 + 41 - lc) tick();
                drive_rx(8'h99, 1'b1);
            end
        join
        repeat (10) tick();
        tests_run++;
        if (wdone_cnt - w0 !== 2 || last_wdone_cyc !== n_coll + 41) begin
            tests_failed++;
            $display("FAIL coll_wdone: got %0d pulses last at N+%0d required 2 last at N+41",
                     wdone_cnt - w0, last_wdone_cyc - n_coll);
        end
        tests_run++;
        if (rdone_cnt - r0 !== 1 || last_rdone_cyc !== n_coll + 42) begin
            tests_failed++;
            $display("FAIL coll_rdone: got %0d pulses at N+%0d required 1 at N+42",
                     rdone_cnt - r0, last_rdone_cyc - n_coll);
        end
        tests_run++;
        if (last_rd !== 32'h0000_0099) begin
            tests_failed++;
            $display("FAIL coll_data: got %h required 00000099", last_rd);
        end
        tests_run++;
        if (both_cnt !== b0) begin
            tests_failed++;
            $display("FAIL coll_overlap: got %0d cycles with both done required 0",
                     both_cnt - b0);
        end
    endtask

    initial begin
        test_reset();
        test_tx_byte();
        test_tx_back_to_back();
        test_rx_pending();
        test_rx_overflow();
        test_frame_err();
        test_reset_mid();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
